unidad_control: RTL and testbench

Sequential control unit that drives the single-cycle MIPS32 datapath. It takes the 6-bit opcode (`instrucc`), the function field and the ALU zero flag from the datapath. From these it generates RegDest, LeerMem, MemaReg, ControlALU, EscrMem, FuenteALU, EscrReg and FuentePC. A small state machine adds:
- a start-up cycle after reset,
- a configurable flush after a taken branch,
- a halt on illegal instructions,
- a retired-instruction counter.

---
 rtl/unidad_control.sv | 157 +++++++++++++++
 tb/tb_unidad_control.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/unidad_control.sv
// Sequential control unit for the single-cycle MIPS32 datapath.
// Combinational decode is gated by a small start-up / flush / halt state machine.
//
// state    | meaning
// ARRANQUE | first cycle after reset, no decode
// EJECUTA  | decode and retire one instruction per cycle
// BURBUJA  | flush cycles after a taken beq, controls forced to 0
// DETENIDO | halted on an illegal instruction until reset
module unidad_control #(
    parameter int ANCHO_CUENTA = 16,
    parameter int BURBUJAS     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              instrucc,
    input  logic [5:0]              funct,
    input  logic                    cero,
    output logic                    RegDest,
    output logic                    LeerMem,
    output logic                    MemaReg,
    output logic [2:0]              ControlALU,
    output logic                    EscrMem,
    output logic                    FuenteALU,
    output logic                    EscrReg,
    output logic                    FuentePC,
    output logic                    detenido,
    output logic [ANCHO_CUENTA-1:0] cuenta_instr,
    output logic [1:0]              estado
);

    typedef enum logic [1:0] {
        ARRANQUE = 2'b00,
        EJECUTA  = 2'b01,
        BURBUJA  = 2'b10,
        DETENIDO = 2'b11
    } estado_t;

    localparam logic [1:0]              CARGA_FLUSH = 2'(BURBUJAS - 1);
    localparam logic [ANCHO_CUENTA-1:0] UNO         = ANCHO_CUENTA'(1);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    estado_t                 r_estado, w_estado_sig;
    logic [1:0]              r_flush, w_flush_sig;
    logic [ANCHO_CUENTA-1:0] r_cuenta;

    logic       w_legal;
    logic       w_salto;
    logic       w_reg_dest, w_leer_mem, w_mem_a_reg, w_escr_mem;
    logic       w_fuente_alu, w_escr_reg, w_fuente_pc;
    logic [2:0] w_ctrl_alu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= ARRANQUE;
            r_flush  <= 2'b00;
            r_cuenta <= '0;
        end else begin
            r_estado <= w_estado_sig;
            r_flush  <= w_flush_sig;
            if (r_estado == EJECUTA && w_legal)
                r_cuenta <= r_cuenta + UNO;
        end
    end

    // Decode is only meaningful in EJECUTA; every other state leaves all controls at 0.
    always_comb begin
        w_legal      = 1'b0;
        w_salto      = 1'b0;
        w_reg_dest   = 1'b0;
        w_leer_mem   = 1'b0;
        w_mem_a_reg  = 1'b0;
        w_escr_mem   = 1'b0;
        w_fuente_alu = 1'b0;
        w_escr_reg   = 1'b0;
        w_fuente_pc  = 1'b0;
        w_ctrl_alu   = 3'b000;
        if (r_estado == EJECUTA) begin
            case (instrucc)
                OP_R: begin
                    w_legal = 1'b1;
                    case (funct)
                        6'b100000: w_ctrl_alu = 3'b010;
                        6'b100010: w_ctrl_alu = 3'b110;
                        6'b100100: w_ctrl_alu = 3'b000;
                        6'b100101: w_ctrl_alu = 3'b001;
                        6'b101010: w_ctrl_alu = 3'b111;
                        default:   w_legal    = 1'b0;
                    endcase
                    w_reg_dest = w_legal;
                    w_escr_reg = w_legal;
                end
                OP_LW: begin
                    w_legal      = 1'b1;
                    w_fuente_alu = 1'b1;
                    w_mem_a_reg  = 1'b1;
                    w_escr_reg   = 1'b1;
                    w_leer_mem   = 1'b1;
                    w_ctrl_alu   = 3'b010;
                end
                OP_SW: begin
                    w_legal      = 1'b1;
                    w_fuente_alu = 1'b1;
                    w_escr_mem   = 1'b1;
                    w_ctrl_alu   = 3'b010;
                end
                OP_BEQ: begin
                    w_legal     = 1'b1;
                    w_ctrl_alu  = 3'b110;
                    w_fuente_pc = cero;
                    w_salto     = cero;
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_flush_sig  = r_flush;
        case (r_estado)
            ARRANQUE: w_estado_sig = EJECUTA;
            EJECUTA: begin
                if (!w_legal) begin
                    w_estado_sig = DETENIDO;
                end else if (w_salto) begin
                    w_estado_sig = BURBUJA;
                    w_flush_sig  = CARGA_FLUSH;
                end
            end
            BURBUJA: begin
                if (r_flush == 2'b00)
                    w_estado_sig = EJECUTA;
                else
                    w_flush_sig = r_flush - 2'b01;
            end
            DETENIDO: w_estado_sig = DETENIDO;
            default:  w_estado_sig = ARRANQUE;
        endcase
    end

    assign RegDest      = w_reg_dest;
    assign LeerMem      = w_leer_mem;
    assign MemaReg      = w_mem_a_reg;
    assign ControlALU   = w_ctrl_alu;
    assign EscrMem      = w_escr_mem;
    assign FuenteALU    = w_fuente_alu;
    assign EscrReg      = w_escr_reg;
    assign FuentePC     = w_fuente_pc;
    assign detenido     = (r_estado == DETENIDO);
    assign cuenta_instr = r_cuenta;
    assign estado       = r_estado;

endmodule

// File: tb/tb_unidad_control.sv
// Directed-vector bench for unidad_control (4-bit counter, two flush cycles).
// The driver queues the expected response per cycle; a monitor checks it mid-cycle.
module tb_unidad_control;

    logic       clk;
    logic       reset;
    logic [5:0] instrucc;
    logic [5:0] funct;
    logic       cero;
    logic       RegDest, LeerMem, MemaReg, EscrMem, FuenteALU, EscrReg, FuentePC;
    logic [2:0] ControlALU;
    logic       detenido;
    logic [3:0] cuenta_instr;
    logic [1:0] estado;

    unidad_control #(.ANCHO_CUENTA(4), .BURBUJAS(2)) dut (
        .clk(clk), .reset(reset), .instrucc(instrucc), .funct(funct), .cero(cero),
        .RegDest(RegDest), .LeerMem(LeerMem), .MemaReg(MemaReg), .ControlALU(ControlALU),
        .EscrMem(EscrMem), .FuenteALU(FuenteALU), .EscrReg(EscrReg), .FuentePC(FuentePC),
        .detenido(detenido), .cuenta_instr(cuenta_instr), .estado(estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {RegDest,LeerMem,MemaReg,ControlALU,EscrMem,FuenteALU,EscrReg,FuentePC}
    localparam logic [9:0] C_NONE = 10'b0_0_0_000_0_0_0_0;
    localparam logic [9:0] C_LW   = 10'b0_1_1_010_0_1_1_0;
    localparam logic [9:0] C_SW   = 10'b0_0_0_010_1_1_0_0;
    localparam logic [9:0] C_BEQT = 10'b0_0_0_110_0_0_0_1;
    localparam logic [9:0] C_BEQN = 10'b0_0_0_110_0_0_0_0;
    localparam logic [9:0] C_ADD  = 10'b1_0_0_010_0_0_1_0;
    localparam logic [9:0] C_SUB  = 10'b1_0_0_110_0_0_1_0;
    localparam logic [9:0] C_AND  = 10'b1_0_0_000_0_0_1_0;
    localparam logic [9:0] C_OR   = 10'b1_0_0_001_0_0_1_0;
    localparam logic [9:0] C_SLT  = 10'b1_0_0_111_0_0_1_0;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ILL = 6'b111111;

    typedef struct packed {
        logic [9:0] ctrl;
        logic [1:0] est;
        logic       det;
        logic [3:0] cnt;
    } esperado_t;

    esperado_t  cola[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] m_cnt    = 4'd0;

    always @(negedge clk) begin
        if (cola.size() > 0) begin
            esperado_t e;
            logic [9:0] ctrl;
            e = cola.pop_front();
            ctrl = {RegDest, LeerMem, MemaReg, ControlALU, EscrMem, FuenteALU, EscrReg, FuentePC};
            n_checks++;
            if (ctrl === e.ctrl && estado === e.est && detenido === e.det && cuenta_instr === e.cnt)
                n_pass++;
            else
                $display("FAIL ciclo t=%0t: got ctrl=%b est=%b det=%b cnt=%0d, expected ctrl=%b est=%b det=%b cnt=%0d",
                         $time, ctrl, estado, detenido, cuenta_instr, e.ctrl, e.est, e.det, e.cnt);
        end
    end

    // Drive one cycle's inputs, queue its expected response, advance to just after the edge.
    task automatic paso(input logic [5:0] op, input logic [5:0] fn, input logic c,
                        input logic [9:0] ctrl, input logic [1:0] est, input logic det,
                        input bit retira);
        esperado_t e;
        instrucc = op;
        funct    = fn;
        cero     = c;
        e.ctrl = ctrl; e.est = est; e.det = det; e.cnt = m_cnt;
        cola.push_back(e);
        if (retira) m_cnt = m_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle; the monitor sees the cleared state before any clock edge.
    task automatic reset_async();
        esperado_t e;
        reset = 1'b0;
        m_cnt = 4'd0;
        e.ctrl = C_NONE; e.est = 2'b00; e.det = 1'b0; e.cnt = 4'd0;
        cola.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; instrucc = OP_LW; funct = 6'd0; cero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        paso(OP_LW, 6'h00, 0, C_NONE, 2'b00, 0, 0);
        paso(OP_LW, 6'h00, 0, C_LW,   2'b01, 0, 1);
        paso(OP_R,  6'h20, 0, C_ADD,  2'b01, 0, 1);
        paso(OP_R,  6'h22, 0, C_SUB,  2'b01, 0, 1);
        paso(OP_R,  6'h24, 0, C_AND,  2'b01, 0, 1);
        paso(OP_R,  6'h25, 0, C_OR,   2'b01, 0, 1);
        paso(OP_R,  6'h2A, 0, C_SLT,  2'b01, 0, 1);
        paso(OP_BEQ,6'h00, 1, C_BEQT, 2'b01, 0, 1);
        paso(OP_SW, 6'h00, 1, C_NONE, 2'b10, 0, 0);
        paso(OP_SW, 6'h00, 0, C_NONE, 2'b10, 0, 0);
        paso(OP_SW, 6'h00, 0, C_SW,   2'b01, 0, 1);
        paso(OP_BEQ,6'h00, 0, C_BEQN, 2'b01, 0, 1);
        paso(OP_BEQ,6'h00, 1, C_BEQT, 2'b01, 0, 1);
        paso(OP_LW, 6'h00, 1, C_NONE, 2'b10, 0, 0);
        paso(OP_LW, 6'h00, 1, C_NONE, 2'b10, 0, 0);
        paso(OP_BEQ,6'h00, 0, C_BEQN, 2'b01, 0, 1);
        paso(OP_R,  6'h20, 1, C_ADD,  2'b01, 0, 1);
        for (int i = 0; i < 4; i++)
            paso(OP_LW, 6'h00, 0, C_LW, 2'b01, 0, 1);
        paso(OP_SW, 6'h00, 0, C_SW,   2'b01, 0, 1);
        paso(OP_ILL,6'h00, 0, C_NONE, 2'b01, 0, 0);
        for (int i = 0; i < 10; i++)
            paso((i % 2) ? OP_LW : OP_BEQ, 6'h20, i[0], C_NONE, 2'b11, 1, 0);
        reset_async();

        paso(OP_R,  6'h20, 0, C_NONE, 2'b00, 0, 0);
        paso(OP_R,  6'h20, 0, C_ADD,  2'b01, 0, 1);
        paso(OP_BEQ,6'h00, 1, C_BEQT, 2'b01, 0, 1);
        paso(OP_LW, 6'h00, 0, C_NONE, 2'b10, 0, 0);
        reset_async();

        paso(OP_R,  6'h00, 0, C_NONE, 2'b00, 0, 0);
        paso(OP_R,  6'h00, 0, C_NONE, 2'b01, 0, 0);
        paso(OP_LW, 6'h00, 0, C_NONE, 2'b11, 1, 0);
        paso(OP_SW, 6'h00, 1, C_NONE, 2'b11, 1, 0);

        repeat (2) @(posedge clk);
        n_checks++;
        if (cola.size() == 0)
            n_pass++;
        else
            $display("FAIL cola_vacia: got %0d pending, expected 0", cola.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
